uart_tx_master: RTL and testbench



---
 rtl/uart_tx_master_if.sv | 22 ++
 rtl/uart_tx_master.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_tx_master.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_master_if.sv
// tilelink: minimal single-beat TileLink-UL bundle used between console logic and the UART slave.
// The master drives the A channel and d_ready; the slave drives a_ready and the D channel.
interface tilelink;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [31:0] a_address;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_data;

  modport master (
    output a_valid, a_opcode, a_address, a_data, d_ready,
    input  a_ready, d_valid, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_address, a_data, d_ready,
    output a_ready, d_valid, d_data
  );
endinterface

// File: rtl/uart_tx_master.sv
// uart_tx_master: drains a local byte FIFO into the console UART's TX_FIFO register over TileLink.
// Every byte is preceded by a STATUS read; the TX write is only issued once Tx-Full (bit 3) reads clear.
// Optional macro UART_TX_INIT_EN: after reset the block first writes 0x3 to CONTROL (reset Rx/Tx
// FIFOs) and waits for its response before any polling starts.
module uart_tx_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 8,
  parameter int          POLL_GAP   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  tilelink.master                       bus,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  localparam logic [2:0]  OP_GET       = 3'd4;
  localparam logic [2:0]  OP_PUT_FULL  = 3'd0;
  localparam logic [31:0] ADDR_TX      = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_STATUS  = BASE_ADDR + 32'h8;
`ifdef UART_TX_INIT_EN
  localparam logic [31:0] ADDR_CONTROL = BASE_ADDR + 32'hc;
`endif

`ifdef UART_TX_INIT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_POLL_REQ, S_POLL_RSP, S_GAP, S_WR_REQ, S_WR_RSP, S_INIT, S_INIT_RSP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_POLL_REQ, S_POLL_RSP, S_GAP, S_WR_REQ, S_WR_RSP
  } state_t;
`endif

  state_t          state, state_nxt;
  logic            a_valid_q, a_valid_nxt;
  logic [2:0]      a_opcode_q, a_opcode_nxt;
  logic [31:0]     a_address_q, a_address_nxt;
  logic [31:0]     a_data_q, a_data_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
`ifdef UART_TX_INIT_EN
  logic            init_done, init_done_nxt;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            push, pop;
  logic [7:0]      head_byte;

  // Only bit 3 of the STATUS word matters; the rest of the D data is intentionally ignored.
  logic unused_d_bits;
  assign unused_d_bits = ^{bus.d_data[31:4], bus.d_data[2:0]};

  // Producer handshake: ready depends only on occupancy, held low while in reset.
  assign tx_ready   = rst_n & (count != CNT_FULL);
  assign push       = tx_valid & tx_ready;
  assign head_byte  = mem[rd_ptr];
  assign fifo_count = count;
  assign busy       = (count != '0) | (state != S_IDLE);

  assign bus.a_valid   = a_valid_q;
  assign bus.a_opcode  = a_opcode_q;
  assign bus.a_address = a_address_q;
  assign bus.a_data    = a_data_q;
`ifdef UART_TX_INIT_EN
  assign bus.d_ready   = (state == S_POLL_RSP) | (state == S_WR_RSP) | (state == S_INIT_RSP);
`else
  assign bus.d_ready   = (state == S_POLL_RSP) | (state == S_WR_RSP);
`endif

  // Byte storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Circular-buffer pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // State register plus the registered A-channel fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      a_valid_q   <= 1'b0;
      a_opcode_q  <= OP_GET;
      a_address_q <= BASE_ADDR;
      a_data_q    <= '0;
      gap_cnt     <= '0;
`ifdef UART_TX_INIT_EN
      init_done   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      a_valid_q   <= a_valid_nxt;
      a_opcode_q  <= a_opcode_nxt;
      a_address_q <= a_address_nxt;
      a_data_q    <= a_data_nxt;
      gap_cnt     <= gap_cnt_nxt;
`ifdef UART_TX_INIT_EN
      init_done   <= init_done_nxt;
`endif
    end
  end

  // Next-state logic; A fields are loaded only when a request is launched and held until a_ready.
  always_comb begin
    state_nxt     = state;
    a_valid_nxt   = a_valid_q;
    a_opcode_nxt  = a_opcode_q;
    a_address_nxt = a_address_q;
    a_data_nxt    = a_data_q;
    gap_cnt_nxt   = gap_cnt;
    pop           = 1'b0;
`ifdef UART_TX_INIT_EN
    init_done_nxt = init_done;
`endif
    case (state)
      S_IDLE: begin
`ifdef UART_TX_INIT_EN
        if (!init_done) begin
          state_nxt     = S_INIT;
          a_valid_nxt   = 1'b1;
          a_opcode_nxt  = OP_PUT_FULL;
          a_address_nxt = ADDR_CONTROL;
          a_data_nxt    = 32'h3;
        end else
`endif
        if (count != '0) begin
          state_nxt     = S_POLL_REQ;
          a_valid_nxt   = 1'b1;
          a_opcode_nxt  = OP_GET;
          a_address_nxt = ADDR_STATUS;
        end
      end
      S_POLL_REQ: begin
        if (bus.a_ready) begin
          a_valid_nxt = 1'b0;
          state_nxt   = S_POLL_RSP;
        end
      end
      S_POLL_RSP: begin
        if (bus.d_valid) begin
          if (bus.d_data[3]) begin
            if (POLL_GAP == 0) begin
              state_nxt     = S_POLL_REQ;
              a_valid_nxt   = 1'b1;
              a_opcode_nxt  = OP_GET;
              a_address_nxt = ADDR_STATUS;
            end else begin
              state_nxt   = S_GAP;
              gap_cnt_nxt = '0;
            end
          end else begin
            state_nxt     = S_WR_REQ;
            a_valid_nxt   = 1'b1;
            a_opcode_nxt  = OP_PUT_FULL;
            a_address_nxt = ADDR_TX;
            a_data_nxt    = {24'b0, head_byte};
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt     = S_POLL_REQ;
          a_valid_nxt   = 1'b1;
          a_opcode_nxt  = OP_GET;
          a_address_nxt = ADDR_STATUS;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_ONE;
        end
      end
      S_WR_REQ: begin
        if (bus.a_ready) begin
          a_valid_nxt = 1'b0;
          pop         = 1'b1;
          state_nxt   = S_WR_RSP;
        end
      end
      S_WR_RSP: begin
        if (bus.d_valid) begin
          state_nxt = S_IDLE;
        end
      end
`ifdef UART_TX_INIT_EN
      S_INIT: begin
        if (bus.a_ready) begin
          a_valid_nxt = 1'b0;
          state_nxt   = S_INIT_RSP;
        end
      end
      S_INIT_RSP: begin
        if (bus.d_valid) begin
          init_done_nxt = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_master.sv
// tb_uart_tx_master: drives bytes into uart_tx_master, plays the UART slave on the TileLink side,
// and scores every A-channel handshake against a queue of expected transactions.
module tb_uart_tx_master;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;
  localparam int          GAP   = 4;
  localparam logic [2:0]  OP_GET = 3'd4;
  localparam logic [2:0]  OP_PUT = 3'd0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [3:0] fifo_count;
  logic       busy;

  tilelink tl();

  uart_tx_master #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .POLL_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(tl),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  txn_t        exp_q[$];
  logic [31:0] status_q[$];
  int          fire_cyc[$];
  logic        stall = 1'b0;
  logic        stall_put = 1'b0;
  logic        hold_d_put = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic expectTxn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.op = op; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic expectByte(input logic [7:0] b);
    expectTxn(OP_GET, BASE + 32'h8, 32'h0);
    expectTxn(OP_PUT, BASE + 32'h4, {24'h0, b});
  endtask

  // Present one byte and hold it until accepted; acc_cyc is the cycle of the accepting edge.
  task automatic applyStimulus(input logic [7:0] b, output int acc_cyc);
    int n;
    tx_valid = 1'b1;
    tx_data  = b;
    n = 0;
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("push_ready", tx_ready, 1);
    acc_cyc = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {exp_q.size(), busy}, 0);
  endtask

  // Slave model: a_ready unless stalled, one D beat one cycle after each accepted A request.
  initial begin : slave
    logic       a_fire_q, d_fire_q, pend;
    logic [2:0] a_op_q, pend_op;
    a_fire_q = 0; d_fire_q = 0; pend = 0; a_op_q = 0; pend_op = 0;
    tl.a_ready = 0; tl.d_valid = 0; tl.d_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tl.a_ready = 0; tl.d_valid = 0; tl.d_data = 0;
        a_fire_q = 0; d_fire_q = 0; pend = 0;
      end else begin
        if (d_fire_q) tl.d_valid = 1'b0;
        if (a_fire_q) begin
          pend    = 1'b1;
          pend_op = a_op_q;
        end
        if (pend && !(hold_d_put && pend_op == OP_PUT)) begin
          tl.d_valid = 1'b1;
          if (pend_op == OP_GET && status_q.size() != 0) tl.d_data = status_q.pop_front();
          else tl.d_data = 32'h0;
          pend = 1'b0;
        end
        tl.a_ready = !stall && !(stall_put && tl.a_opcode == OP_PUT);
        a_fire_q   = tl.a_valid & tl.a_ready;
        a_op_q     = tl.a_opcode;
        d_fire_q   = tl.d_valid & tl.d_ready;
      end
    end
  end

  // Monitor: every A handshake is popped against the expected queue; Get data is don't-care.
  initial begin : monitor
    txn_t act, e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && tl.a_valid && tl.a_ready) begin
        act.op   = tl.a_opcode;
        act.addr = tl.a_address;
        act.data = (tl.a_opcode == OP_GET) ? 32'h0 : tl.a_data;
        fire_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_txn", act, 0);
          if (act == 0) checkOutput("unexpected_txn_valid", tl.a_valid, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("a_txn", act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int pc;
    int n;
    tx_valid = 1'b0;
    tx_data  = 8'h0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_a_valid", tl.a_valid, 0);
    checkOutput("rst_d_ready", tl.d_ready, 0);
    checkOutput("rst_a_opcode", tl.a_opcode, OP_GET);
    checkOutput("rst_a_address", tl.a_address, BASE);
    checkOutput("rst_a_data", tl.a_data, 0);
    checkOutput("rst_tx_ready", tx_ready, 0);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_busy", busy, 0);
`ifdef UART_TX_INIT_EN
    expectTxn(OP_PUT, BASE + 32'hc, 32'h3);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    waitDrain("init_drain", 50);
    checkOutput("idle_tx_ready", tx_ready, 1);

    // Single byte, STATUS clear: Get then Put, 4 cycles from push edge to write accept.
    fire_cyc.delete();
    expectByte(8'h41);
    applyStimulus(8'h41, pc);
    checkOutput("t1_count", fifo_count, 1);
    checkOutput("t1_busy", busy, 1);
    waitDrain("t1_drain", 50);
    checkOutput("t1_count_end", fifo_count, 0);
    checkOutput("t1_fires", fire_cyc.size(), 2);
    if (fire_cyc.size() == 2) checkOutput("t1_latency", fire_cyc[1] - pc, 4);

    // Tx-Full three times, then clear: Gets spaced by POLL_GAP idle cycles, then one write.
    fire_cyc.delete();
    status_q.push_back(32'h08); status_q.push_back(32'h08);
    status_q.push_back(32'h08); status_q.push_back(32'h00);
    repeat (3) expectTxn(OP_GET, BASE + 32'h8, 32'h0);
    expectByte(8'h52);
    applyStimulus(8'h52, pc);
    waitDrain("t2_drain", 150);
    checkOutput("t2_fires", fire_cyc.size(), 5);
    if (fire_cyc.size() == 5) begin
      for (int i = 0; i < 3; i++) checkOutput("t2_poll_spacing", fire_cyc[i+1] - fire_cyc[i], GAP + 2);
      checkOutput("t2_get_to_put", fire_cyc[4] - fire_cyc[3], 2);
    end

    // FIFO full with the slave stalled; ninth byte waits, then all drain in order.
    stall = 1'b1;
    for (int i = 0; i < 9; i++) expectByte(8'(8'h30 + i));
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h30 + i), pc);
    checkOutput("t3_full_count", fifo_count, 8);
    checkOutput("t3_full_ready", tx_ready, 0);
    tx_valid = 1'b1;
    tx_data  = 8'h38;
    repeat (3) @(negedge clk);
    checkOutput("t3_held_count", {tx_ready, fifo_count}, {1'b0, 4'd8});
    stall = 1'b0;
    applyStimulus(8'h38, pc);
    waitDrain("t3_drain", 400);

    // Push on the same edge as the write accept: count unchanged, order kept.
    expectByte(8'h61); expectByte(8'h62); expectByte(8'h63); expectByte(8'h64);
    applyStimulus(8'h61, pc);
    applyStimulus(8'h62, pc);
    applyStimulus(8'h63, pc);
    n = 0;
    @(negedge clk); #1;
    while (!(tl.a_valid && tl.a_opcode == OP_PUT && tl.a_ready) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("t4_put_seen", {tl.a_valid, tl.a_opcode}, {1'b1, OP_PUT});
    checkOutput("t4_count_before", fifo_count, 3);
    tx_valid = 1'b1;
    tx_data  = 8'h64;
    @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("t4_count_after", fifo_count, 3);
    waitDrain("t4_drain", 200);

    // A-channel held for 10 cycles while a_ready stays low on the write.
    stall_put = 1'b1;
    expectByte(8'h77);
    applyStimulus(8'h77, pc);
    n = 0;
    while (!(tl.a_valid && tl.a_opcode == OP_PUT) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("t5_a_valid", {tl.a_valid, tl.a_ready}, 2'b10);
      checkOutput("t5_addr_data", {tl.a_address, tl.a_data}, {BASE + 32'h4, 32'h77});
      @(negedge clk); #1;
    end
    stall_put = 1'b0;
    waitDrain("t5_drain", 50);

    // Reset while waiting for the write response with three bytes still queued.
    hold_d_put = 1'b1;
    expectByte(8'hA0);
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'hA0 + i), pc);
    n = 0;
    while (!(fifo_count == 3 && tl.d_ready && !tl.a_valid && tl.a_opcode == OP_PUT) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_in_wr_rsp", {fifo_count, tl.d_ready}, {4'd3, 1'b1});
    checkOutput("t6_exp_empty", exp_q.size(), 0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_a_valid", tl.a_valid, 0);
    checkOutput("t6_rst_d_ready", tl.d_ready, 0);
    checkOutput("t6_rst_count", fifo_count, 0);
    checkOutput("t6_rst_busy", busy, 0);
    hold_d_put = 1'b0;
    @(negedge clk);
`ifdef UART_TX_INIT_EN
    expectTxn(OP_PUT, BASE + 32'hc, 32'h3);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    waitDrain("t6_drain", 50);
    repeat (10) @(negedge clk);
    checkOutput("t6_final_count", {fifo_count, busy}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
